uart_tx_fifo: RTL and testbench

- Serial transmitter for the host link. It is the return path opposite the byte receiver that feeds the processor.
- Accepts result words from the core through a valid strobe and buffers them in a small FIFO.
- Serialises each word as 8N1 UART (LSB first) on a single line back to the host.
- Sits between the processor's result logic and the board TX pin.

---
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Core-side handshake and serial-line signals of the buffered UART transmitter.
// The core drives the master modport; the transmitter uses the slave modport.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_TX_Byte;
    logic              i_TX_DV;
    logic              o_TX_Ready;
    logic              o_TX_Serial;
    logic              o_TX_Active;
    logic              o_TX_Done;
    logic              o_Overflow;

    modport master (
        output i_TX_Byte, i_TX_DV,
        input  o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done, o_Overflow
    );

    modport slave (
        input  i_TX_Byte, i_TX_DV,
        output o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done, o_Overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: words pushed by the core go out LSB first as 8N1 frames.
// Defining UART_TX_PARITY_EN inserts an even-parity bit after the data bits (8E1).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          CLOCK_50,
    input  logic          KEY,
    uart_tx_fifo_if.slave tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, empty, push, pop;
    logic              overflow_q;

    state_t            state_q, state_d;
    logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              bit_last;

    // Ready comes from the registered count only, so a pop in the same cycle never rescues a write to a full FIFO.
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = tx.i_TX_DV && !full;

    assign tx.o_TX_Ready  = !full;
    assign tx.o_TX_Serial = serial_q;
    assign tx.o_TX_Active = active_q;
    assign tx.o_TX_Done   = done_q;
    assign tx.o_Overflow  = overflow_q;

    always_ff @(posedge CLOCK_50) begin
        if (push)
            mem[wr_ptr] <= tx.i_TX_Byte;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= tx.i_TX_DV && full;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign bit_last = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

    // Serial/active/done are computed for the next cycle so the line itself is a flop output.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = mem[rd_ptr];
                    clk_cnt_d = '0;
                    state_d   = S_START;
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_last) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    serial_d  = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == IW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = S_PARITY;
                        serial_d = ^shift_q;
`else
                        state_d  = S_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        serial_d  = shift_q[bit_idx_d];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_last) begin
                    clk_cnt_d = '0;
                    state_d   = S_STOP;
                    serial_d  = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                serial_d = 1'b1;
                if (bit_last) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    active_d  = 1'b0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: accepted words go to a scoreboard queue, and each
// received frame is checked cycle by cycle against the word popped from it.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic CLOCK_50 = 1'b0;
    logic KEY;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] sb [$];

    uart_tx_fifo_if #(.DATA_W(8)) tx ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .tx       (tx)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the word is sampled at the following posedge.
    task automatic push1(input logic [7:0] b, input bit exp_rdy);
        chk("ready", 32'(tx.o_TX_Ready), 32'(exp_rdy));
        tx.i_TX_DV   = 1'b1;
        tx.i_TX_Byte = b;
        if (exp_rdy) sb.push_back(b);
        @(negedge CLOCK_50);
        tx.i_TX_DV = 1'b0;
        chk("overflow", 32'(tx.o_Overflow), 32'(!exp_rdy));
    endtask

    // Start bit must first be seen exactly lat negedges after the call.
    task automatic rx_frame(input int lat, input string tag);
        logic [7:0]  b;
        logic [11:0] frm;
        for (int i = 1; i < lat; i++) begin
            @(negedge CLOCK_50);
            chk({tag, " pre-start"}, 32'(tx.o_TX_Serial), 32'(1));
        end
        @(negedge CLOCK_50);
        chk({tag, " sb nonempty"}, 32'(sb.size() > 0), 32'(1));
        b = (sb.size() > 0) ? sb.pop_front() : 8'h00;
`ifdef UART_TX_PARITY_EN
        frm = {1'b0, 1'b1, ^b, b, 1'b0};
`else
        frm = {2'b00, 1'b1, b, 1'b0};
`endif
        for (int k = 0; k < NB * CPB; k++) begin
            if (k > 0) @(negedge CLOCK_50);
            chk({tag, " line/active/done"},
                32'({tx.o_TX_Serial, tx.o_TX_Active, tx.o_TX_Done}),
                32'({frm[k / CPB], 1'b1, 1'b0}));
        end
        @(negedge CLOCK_50);
        chk({tag, " done pulse"},
            32'({tx.o_TX_Serial, tx.o_TX_Active, tx.o_TX_Done}), 32'(3'b101));
    endtask

    task automatic quiet(input int n, input string tag);
        int bad = 0;
        repeat (n) begin
            @(negedge CLOCK_50);
            if ({tx.o_TX_Serial, tx.o_TX_Active, tx.o_TX_Done} !== 3'b100) bad++;
        end
        chk(tag, 32'(bad), 32'(0));
    endtask

    initial begin
        KEY          = 1'b0;
        tx.i_TX_DV   = 1'b0;
        tx.i_TX_Byte = 8'h00;
        #20;
        chk("reset serial",   32'(tx.o_TX_Serial), 32'(1));
        chk("reset ready",    32'(tx.o_TX_Ready),  32'(1));
        chk("reset active",   32'(tx.o_TX_Active), 32'(0));
        chk("reset done",     32'(tx.o_TX_Done),   32'(0));
        chk("reset overflow", 32'(tx.o_Overflow),  32'(0));
        KEY = 1'b1;
        @(negedge CLOCK_50);

        // single frame, exact latency and length
        fork
            push1(8'hA5, 1'b1);
            rx_frame(2, "t1");
        join
        quiet(5, "t1 idle after");

        // back-to-back frames, one idle clock between them
        fork
            begin
                push1(8'h01, 1'b1);
                push1(8'h02, 1'b1);
                push1(8'h03, 1'b1);
            end
            begin
                rx_frame(2, "t2 f0");
                rx_frame(1, "t2 f1");
                rx_frame(1, "t2 f2");
            end
        join
        quiet(10, "t2 idle after");
        chk("t2 sb empty", 32'(sb.size()), 32'(0));

        // overflow: 0x10 pops immediately, 0x11..0x14 fill the FIFO, 0x15 dropped
        fork
            begin
                push1(8'h10, 1'b1);
                push1(8'h11, 1'b1);
                push1(8'h12, 1'b1);
                push1(8'h13, 1'b1);
                push1(8'h14, 1'b1);
                push1(8'h15, 1'b0);
                @(negedge CLOCK_50);
                chk("t3 overflow one cycle", 32'(tx.o_Overflow), 32'(0));
            end
            begin
                rx_frame(2, "t3 f0");
                for (int f = 1; f < 5; f++) rx_frame(1, "t3 fn");
            end
        join
        quiet(60, "t3 no sixth frame");
        chk("t3 sb empty", 32'(sb.size()), 32'(0));

        // asynchronous reset during data bit 3
        push1(8'hFF, 1'b1);
        sb.delete();
        repeat (18) @(negedge CLOCK_50);
        chk("t4 active mid-frame", 32'(tx.o_TX_Active), 32'(1));
        #2 KEY = 1'b0;
        #1;
        chk("t4 reset serial", 32'(tx.o_TX_Serial), 32'(1));
        chk("t4 reset active", 32'(tx.o_TX_Active), 32'(0));
        chk("t4 reset ready",  32'(tx.o_TX_Ready),  32'(1));
        @(negedge CLOCK_50);
        KEY = 1'b1;
        quiet(60, "t4 no frame after reset");

        // data is captured at push; later input changes are ignored
        fork
            begin
                push1(8'h3C, 1'b1);
                repeat (10) @(negedge CLOCK_50);
                tx.i_TX_Byte = 8'hC3;
            end
            rx_frame(2, "t6");
        join
        quiet(50, "t6 no second frame");

`ifdef UART_TX_PARITY_EN
        fork
            push1(8'h07, 1'b1);
            rx_frame(2, "t5 par1");
        join
        quiet(3, "t5 gap");
        fork
            push1(8'h03, 1'b1);
            rx_frame(2, "t5 par0");
        join
        quiet(3, "t5 idle after");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
